// File: rtl/mux_arbiter_if.sv
// Handshake bundle for the two-way result-bus arbiter:
// requesters a/b, registered output c and grant counters.
interface mux_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] a;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] b;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] c;
   logic             c_sel;
   logic             c_valid;
   logic             c_ready;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   modport master (
      output a, a_valid, b, b_valid, c_ready,
      input  a_ready, b_ready, c, c_sel, c_valid,
      input  cnt_a, cnt_b
   );

   modport slave (
      input  a, a_valid, b, b_valid, c_ready,
      output a_ready, b_ready, c, c_sel, c_valid,
      output cnt_a, cnt_b
   );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin 2:1 arbiter feeding one registered output slot.
// MUX_ARBITER_CNT_EN builds saturating per-side grant counters.
module mux_arbiter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input logic          clk,
   input logic          reset,
   mux_arbiter_if.slave bus
);
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   logic             last_grant;
   logic [WIDTH-1:0] c_q;
   logic             c_sel_q;
   logic             c_valid_q;
   logic             slot_free;
   logic             pick_a;
   logic             pick_b;
   logic             take_a;
   logic             take_b;
   logic             xfer;

   // last_grant=1 means B went last, so A wins a tie
   always_comb begin
      pick_a = bus.a_valid & (~bus.b_valid | last_grant);
      pick_b = bus.b_valid & (~bus.a_valid | ~last_grant);
   end

   assign slot_free   = (state == EMPTY) | bus.c_ready;
   assign take_a      = slot_free & pick_a;
   assign take_b      = slot_free & pick_b;
   assign xfer        = take_a | take_b;
   assign bus.a_ready = take_a;
   assign bus.b_ready = take_b;
   assign bus.c       = c_q;
   assign bus.c_sel   = c_sel_q;
   assign bus.c_valid = c_valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         c_q        <= '0;
         c_sel_q    <= 1'b0;
         c_valid_q  <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         if (xfer) begin
            c_q        <= take_b ? bus.b : bus.a;
            c_sel_q    <= take_b;
            last_grant <= take_b;
         end
         unique case (state)
            EMPTY: begin
               if (xfer) begin
                  state     <= FULL;
                  c_valid_q <= 1'b1;
               end
            end
            FULL: begin
               if (!xfer && bus.c_ready) begin
                  state     <= EMPTY;
                  c_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef MUX_ARBITER_CNT_EN
   logic [CNT_W-1:0] cnt_a_q;
   logic [CNT_W-1:0] cnt_b_q;

   // saturate rather than wrap so long runs stay monotonic
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         if (take_a && cnt_a_q != '1)
            cnt_a_q <= cnt_a_q + 1'b1;
         if (take_b && cnt_b_q != '1)
            cnt_b_q <= cnt_b_q + 1'b1;
      end
   end

   assign bus.cnt_a = cnt_a_q;
   assign bus.cnt_b = cnt_b_q;
`else
   assign bus.cnt_a = '0;
   assign bus.cnt_b = '0;
`endif
endmodule
